// File: rtl/booth_pkg.sv
// Shared constants for the radix-2 Booth multiplier: shift-register ctrl codes and controller states.
package booth_pkg;

  localparam int unsigned CTRL_W = 2;

  localparam logic [CTRL_W-1:0] CTRL_LOAD  = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_RESET = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_SHIFT = 2'b10;
  localparam logic [CTRL_W-1:0] CTRL_HOLD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/booth_iter_cnt.sv
// Loadable iteration down-counter; last_c flags the final iteration (count == 1).
module booth_iter_cnt #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last_c
);

  // Decrement is guarded so the counter can never wrap below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(WIDTH);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last_c = (count == CNT_W'(1));

endmodule

// File: rtl/booth_controller.sv
// Sequencing FSM for a radix-2 Booth multiplier driving the A/Q shift registers and ALU.
// Define BOOTH_SKIP_EN to fold 00/11 iterations into a single EVAL cycle (variable latency).
module booth_controller
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              q_lsb,
  output logic [CTRL_W-1:0] a_ctrl,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic              m_load,
  output logic              alu_sub,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  iter_cnt
);

`ifdef BOOTH_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  state_t state;
  state_t state_nxt;
  logic   q_m1;
  logic   last_c;
  logic   pair_eq_c;
  logic   shift_now_c;

  // Equal {Q0,Q-1} pairs need no add/sub; with skipping enabled they shift straight from EVAL.
  assign pair_eq_c   = (q_lsb == q_m1);
  assign shift_now_c = (state == ST_SHIFT) || (SKIP_EN && (state == ST_EVAL) && pair_eq_c);

  booth_iter_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ST_LOAD),
    .dec    (shift_now_c),
    .count  (iter_cnt),
    .last_c (last_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Q[-1] tracks the bit shifted out of Q on each iteration.
  always_ff @(posedge clk) begin
    if (rst || (state == ST_LOAD)) begin
      q_m1 <= 1'b0;
    end else if (shift_now_c) begin
      q_m1 <= q_lsb;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (shift_now_c) begin
          state_nxt = last_c ? ST_DONE : ST_EVAL;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: state_nxt = last_c ? ST_DONE : ST_EVAL;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    a_ctrl  = CTRL_HOLD;
    q_ctrl  = CTRL_HOLD;
    m_load  = 1'b0;
    alu_sub = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_LOAD: begin
        a_ctrl = CTRL_RESET;
        q_ctrl = CTRL_LOAD;
        m_load = 1'b1;
        busy   = 1'b1;
      end
      ST_EVAL: begin
        busy = 1'b1;
        case ({q_lsb, q_m1})
          2'b10: begin
            a_ctrl  = CTRL_LOAD;
            alu_sub = 1'b1;
          end
          2'b01: a_ctrl = CTRL_LOAD;
          default: begin
            if (SKIP_EN) begin
              a_ctrl = CTRL_SHIFT;
              q_ctrl = CTRL_SHIFT;
            end
          end
        endcase
      end
      ST_SHIFT: begin
        a_ctrl = CTRL_SHIFT;
        q_ctrl = CTRL_SHIFT;
        busy   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
